// File: rtl/ramdp_arb.sv
// ramdp_arb: round-robin arbiter/sequencer sharing one dual-port RAM among NR
// requesters. Up to two grants per cycle: first winner on port A, second on B.
// RAM drive signals are registered; read data returns to the requester two
// cycles after its grant.
// Optional feature: define RAMDP_ARB_COLLISION_EN to keep a port B candidate
// from being granted when it hits the port A winner's address and either of
// the two is a write.
module ramdp_arb #(
    parameter int NR = 4,
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    req,
    input  logic [NR-1:0]    req_we,
    input  logic [NR*AW-1:0] req_addr,
    input  logic [NR*DW-1:0] req_wdata,
    output logic [NR-1:0]    gnt,
    output logic [NR-1:0]    rvalid,
    output logic [NR*DW-1:0] rdata,
    output logic             en_a,
    output logic             we_a,
    output logic [AW-1:0]    addr_a,
    output logic [DW-1:0]    din_a,
    input  logic [DW-1:0]    dout_a,
    output logic             en_b,
    output logic             we_b,
    output logic [AW-1:0]    addr_b,
    output logic [DW-1:0]    din_b,
    input  logic [DW-1:0]    dout_b
);

    localparam int PW = $clog2(NR);

    typedef struct packed {
        logic          vld;
        logic          rd;
        logic [PW-1:0] idx;
    } tag_t;

    logic [PW-1:0]    ptr;
    logic             found_a, found_b;
    logic [PW-1:0]    win_a, win_b, last_win;
    logic             collide;
    int unsigned      cand;
    tag_t             tag_a_n, tag_b_n;
    tag_t             s1_a, s1_b, s2_a, s2_b;
    logic [NR*DW-1:0] rdata_hold;

    // Cyclic scan from ptr: first asserted request wins A, next eligible wins B.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        win_a   = '0;
        win_b   = '0;
        cand    = 0;
        collide = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            // Explicit wrap so non-power-of-two NR works.
            cand = 32'(ptr) + k;
            if (cand >= 32'(NR))
                cand = cand - 32'(NR);
`ifdef RAMDP_ARB_COLLISION_EN
            collide = found_a
                   && (req_addr[cand*AW +: AW] == req_addr[32'(win_a)*AW +: AW])
                   && (req_we[cand] || req_we[win_a]);
`else
            collide = 1'b0;
`endif
            if (req[cand]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    win_a   = PW'(cand);
                end else if (!found_b && !collide) begin
                    found_b = 1'b1;
                    win_b   = PW'(cand);
                end
            end
        end
    end

    // Grant pulses, suppressed during reset.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (found_a) gnt[win_a] = 1'b1;
            if (found_b) gnt[win_b] = 1'b1;
        end
    end

    assign last_win = found_b ? win_b : win_a;
    assign tag_a_n  = '{vld: found_a, rd: ~req_we[win_a], idx: win_a};
    assign tag_b_n  = '{vld: found_b, rd: ~req_we[win_b], idx: win_b};

    // Round-robin pointer: one past the last winner, held when idle.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (found_a)
            ptr <= (last_win == PW'(NR - 1)) ? '0 : last_win + 1'b1;
    end

    // Register winners onto the RAM ports; idle ports keep address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_a   <= 1'b0;
            we_a   <= 1'b0;
            addr_a <= '0;
            din_a  <= '0;
            en_b   <= 1'b0;
            we_b   <= 1'b0;
            addr_b <= '0;
            din_b  <= '0;
        end else begin
            en_a <= found_a;
            we_a <= found_a & req_we[win_a];
            en_b <= found_b;
            we_b <= found_b & req_we[win_b];
            if (found_a) begin
                addr_a <= req_addr[32'(win_a)*AW +: AW];
                din_a  <= req_wdata[32'(win_a)*DW +: DW];
            end
            if (found_b) begin
                addr_b <= req_addr[32'(win_b)*AW +: AW];
                din_b  <= req_wdata[32'(win_b)*DW +: DW];
            end
        end
    end

    // Two-stage tag pipeline per port, aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a <= '0;
            s1_b <= '0;
            s2_a <= '0;
            s2_b <= '0;
        end else begin
            s1_a <= tag_a_n;
            s1_b <= tag_b_n;
            s2_a <= s1_a;
            s2_b <= s1_b;
        end
    end

    // Route RAM read data to the owning requester; others show held data.
    always_comb begin
        rvalid = '0;
        rdata  = rdata_hold;
        if (!rst) begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (s2_a.vld && s2_a.rd && (s2_a.idx == PW'(i))) begin
                    rvalid[i]           = 1'b1;
                    rdata[i*DW +: DW]   = dout_a;
                end
                if (s2_b.vld && s2_b.rd && (s2_b.idx == PW'(i))) begin
                    rvalid[i]           = 1'b1;
                    rdata[i*DW +: DW]   = dout_b;
                end
            end
        end
    end

    // Capture returned data so rdata holds between rvalid pulses.
    always_ff @(posedge clk) begin
        if (rst)
            rdata_hold <= '0;
        else
            rdata_hold <= rdata;
    end

endmodule

// File: tb/tb_ramdp_arb.sv
// Directed testbench for ramdp_arb with a behavioural dual-port RAM
// (1-cycle registered read). Unwritten RAM words read as 16'h1000 | addr.
module tb_ramdp_arb;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    req_we = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]    gnt, rvalid;
    logic [NR*DW-1:0] rdata;
    logic             en_a, we_a, en_b, we_b;
    logic [AW-1:0]    addr_a, addr_b;
    logic [DW-1:0]    din_a, din_b;
    logic [DW-1:0]    dout_a = '0;
    logic [DW-1:0]    dout_b = '0;

    int total = 0;
    int bad   = 0;

    ramdp_arb #(.NR(NR), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
    );

    always #5 clk = ~clk;

    // Behavioural RAM; reset clears which words have been written.
    logic [DW-1:0] mem [256];
    logic [255:0]  mv;
    always @(posedge clk) begin
        if (rst) begin
            mv <= '0;
        end else begin
            if (en_a) begin
                if (we_a) begin mem[addr_a] <= din_a; mv[addr_a] <= 1'b1; end
                dout_a <= mv[addr_a] ? mem[addr_a] : (16'h1000 | 16'(addr_a));
            end
            if (en_b) begin
                if (we_b) begin mem[addr_b] <= din_b; mv[addr_b] <= 1'b1; end
                dout_b <= mv[addr_b] ? mem[addr_b] : (16'h1000 | 16'(addr_b));
            end
        end
    end

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req[i]               = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({gnt, en_a, en_b, rvalid} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got gnt=%b en=%b%b rvalid=%b want all 0",
                     gnt, en_a, en_b, rvalid);
        end
        total++;
        if (rdata !== '0) begin
            bad++;
            $display("FAIL reset_rdata got=%h want=0", rdata);
        end
        req = '0;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            total++;
            if ({gnt, en_a, en_b, rvalid} !== '0) begin
                bad++;
                $display("FAIL idle_%0d got gnt=%b en=%b%b rvalid=%b want all 0",
                         c, gnt, en_a, en_b, rvalid);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 16'hBEEF);
        #1;
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL wr_gnt got=%b want=0001", gnt); end
        @(posedge clk); #1;
        total++;
        if ({en_a, we_a, addr_a, din_a, en_b} !== {1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0}) begin
            bad++;
            $display("FAIL wr_issue got en_a=%b we_a=%b addr_a=%h din_a=%h en_b=%b want 1 1 10 beef 0",
                     en_a, we_a, addr_a, din_a, en_b);
        end
        @(negedge clk);
        req = '0;
        set_req(0, 1'b0, 8'h10, 16'h0000);
        #1;
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL rd_gnt got=%b want=0001", gnt); end
        @(posedge clk); #1;
        total++;
        if ({en_a, we_a, addr_a, en_b} !== {1'b1, 1'b0, 8'h10, 1'b0}) begin
            bad++;
            $display("FAIL rd_issue got en_a=%b we_a=%b addr_a=%h en_b=%b want 1 0 10 0",
                     en_a, we_a, addr_a, en_b);
        end
        total++;
        if (rvalid !== 4'b0000) begin bad++; $display("FAIL wr_no_rvalid got=%b want=0000", rvalid); end
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        total++;
        if (rvalid !== 4'b0001 || rdata[15:0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL rd_return got rvalid=%b rdata0=%h want 0001 beef", rvalid, rdata[15:0]);
        end
        @(posedge clk); #1;
        total++;
        if (rvalid !== 4'b0000 || rdata[15:0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL rd_hold got rvalid=%b rdata0=%h want 0000 beef", rvalid, rdata[15:0]);
        end
    endtask

    task automatic test_all_read();
        logic [NR-1:0] exp;
        int g, ia, ib;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'(8'h40 + i), 16'h0000);
            end else begin
                req = '0;
            end
            #1;
            if (c < 4) begin
                exp = (c % 2 == 0) ? 4'b0011 : 4'b1100;
                total++;
                if (gnt !== exp) begin bad++; $display("FAIL all_gnt_%0d got=%b want=%b", c, gnt, exp); end
            end
            @(posedge clk); #1;
            if (c < 4) begin
                ia = (c % 2 == 0) ? 0 : 2;
                total++;
                if ({en_a, en_b, addr_a, addr_b} !== {1'b1, 1'b1, 8'(8'h40 + ia), 8'(8'h41 + ia)}) begin
                    bad++;
                    $display("FAIL all_issue_%0d got en=%b%b addr_a=%h addr_b=%h want 11 %h %h",
                             c, en_a, en_b, addr_a, addr_b, 8'h40 + ia, 8'h41 + ia);
                end
            end
            if (c >= 1 && c <= 4) begin
                g   = c - 1;
                ia  = (g % 2 == 0) ? 0 : 2;
                ib  = ia + 1;
                exp = (g % 2 == 0) ? 4'b0011 : 4'b1100;
                total++;
                if (rvalid !== exp || rdata[ia*DW +: DW] !== 16'(16'h1040 + ia)
                    || rdata[ib*DW +: DW] !== 16'(16'h1040 + ib)) begin
                    bad++;
                    $display("FAIL all_ret_%0d got rvalid=%b rd%0d=%h rd%0d=%h want %b %h %h",
                             g, rvalid, ia, rdata[ia*DW +: DW], ib, rdata[ib*DW +: DW],
                             exp, 16'h1040 + ia, 16'h1040 + ib);
                end
            end
        end
    endtask

    task automatic test_ptr();
        @(negedge clk);
        set_req(0, 1'b0, 8'h50, 16'h0);
        set_req(1, 1'b0, 8'h51, 16'h0);
        #1;
        total++;
        if (gnt !== 4'b0011) begin bad++; $display("FAIL ptr_pre_gnt got=%b want=0011", gnt); end
        @(negedge clk);
        req = '0;
        set_req(1, 1'b0, 8'h51, 16'h0);
        set_req(3, 1'b0, 8'h53, 16'h0);
        #1;
        total++;
        if (gnt !== 4'b1010) begin bad++; $display("FAIL ptr_gnt13 got=%b want=1010", gnt); end
        @(posedge clk); #1;
        total++;
        if ({en_a, en_b, addr_a, addr_b} !== {1'b1, 1'b1, 8'h53, 8'h51}) begin
            bad++;
            $display("FAIL ptr_ports got en=%b%b addr_a=%h addr_b=%h want 11 53 51",
                     en_a, en_b, addr_a, addr_b);
        end
        @(negedge clk);
        req = '0;
        for (int i = 1; i < NR; i++) set_req(i, 1'b0, 8'(8'h50 + i), 16'h0);
        #1;
        total++;
        if (gnt !== 4'b1100) begin bad++; $display("FAIL ptr_is2 got=%b want=1100", gnt); end
        @(negedge clk);
        req = '0;
        set_req(2, 1'b0, 8'h60, 16'h0);
        #1;
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
        @(posedge clk); #1;
        total++;
        if ({en_a, addr_a, en_b, we_b} !== {1'b1, 8'h60, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL single_port got en_a=%b addr_a=%h en_b=%b we_b=%b want 1 60 0 0",
                     en_a, addr_a, en_b, we_b);
        end
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_collision();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 8'h20, 16'hCAFE);
        set_req(1, 1'b0, 8'h20, 16'h0);
        set_req(2, 1'b0, 8'h30, 16'h0);
        #1;
`ifdef RAMDP_ARB_COLLISION_EN
        total++;
        if (gnt !== 4'b0101) begin bad++; $display("FAIL col_gnt1 got=%b want=0101", gnt); end
        @(negedge clk);
        req = '0;
        set_req(1, 1'b0, 8'h20, 16'h0);
        #1;
        total++;
        if (gnt !== 4'b0010) begin bad++; $display("FAIL col_gnt2 got=%b want=0010", gnt); end
        @(posedge clk); #1;
        total++;
        if (rvalid !== 4'b0100 || rdata[2*DW +: DW] !== 16'h1030) begin
            bad++;
            $display("FAIL col_ret2 got rvalid=%b rd2=%h want 0100 1030", rvalid, rdata[2*DW +: DW]);
        end
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        total++;
        if (rvalid !== 4'b0010 || rdata[1*DW +: DW] !== 16'hCAFE) begin
            bad++;
            $display("FAIL col_ret1 got rvalid=%b rd1=%h want 0010 cafe", rvalid, rdata[1*DW +: DW]);
        end
`else
        total++;
        if (gnt !== 4'b0011) begin bad++; $display("FAIL col_gnt1 got=%b want=0011", gnt); end
        @(negedge clk);
        req = '0;
        set_req(2, 1'b0, 8'h30, 16'h0);
        #1;
        total++;
        if (gnt !== 4'b0100) begin bad++; $display("FAIL col_gnt2 got=%b want=0100", gnt); end
        @(posedge clk); #1;
        total++;
        if (rvalid !== 4'b0010) begin bad++; $display("FAIL col_ret1 got rvalid=%b want=0010", rvalid); end
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        total++;
        if (rvalid !== 4'b0100 || rdata[2*DW +: DW] !== 16'h1030) begin
            bad++;
            $display("FAIL col_ret2 got rvalid=%b rd2=%h want 0100 1030", rvalid, rdata[2*DW +: DW]);
        end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(0, 1'b0, 8'h40, 16'h0);
        #1;
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_gnt got=%b want=0001", gnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_gnt_rst got=%b want=0000", gnt); end
        @(posedge clk); #1;
        total++;
        if ({rvalid, en_a, en_b} !== '0) begin
            bad++;
            $display("FAIL mid_after got rvalid=%b en=%b%b want 0000 00", rvalid, en_a, en_b);
        end
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (rvalid !== 4'b0000) begin bad++; $display("FAIL mid_quiet_%0d got=%b want=0000", c, rvalid); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_all_read();
        test_ptr();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
